// File: rtl/bat_pkg.sv
// Shared definitions for the battery bar generator: default sizes, FSM states
// and the thermometer-mask helper.
package bat_pkg;

  localparam int SEGS_DEF = 28;
  localparam int LW_DEF   = 5;
  localparam int MAX_SEGS = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    STEP = 2'd2
  } state_t;

  // Thermometer mask, wide enough for any supported SEGS; callers truncate.
  function automatic logic [MAX_SEGS-1:0] therm(input int unsigned level);
    logic [MAX_SEGS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_SEGS; i++) begin
      m[i] = (i < level);
    end
    return m;
  endfunction

endpackage

// File: rtl/vsync_tick.sv
// Brings the renderer's active-low vsync into clk and emits a one-cycle
// frame_tick three cycles after each falling edge.
module vsync_tick (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic frame_tick
);

  logic vs_p0, vs_p1, vs_p2;

  // Flops reset high so an idle-high vsync never looks like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_p0      <= 1'b1;
      vs_p1      <= 1'b1;
      vs_p2      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      vs_p0      <= vsync;
      vs_p1      <= vs_p0;
      vs_p2      <= vs_p1;
      frame_tick <= vs_p2 & ~vs_p1;
    end
  end

endmodule

// File: rtl/bat_level_gen.sv
// Battery bar mask generator: animates the displayed level one segment per
// STEP_FRAMES frames toward the requested level. Optional macro: BAT_LOW_BLINK_EN.
module bat_level_gen
  import bat_pkg::*;
#(
  parameter int SEGS         = SEGS_DEF,
  parameter int LW           = LW_DEF,
  parameter int STEP_FRAMES  = 2,
  parameter int LOW_THRESH   = 5,
  parameter int BLINK_FRAMES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [LW-1:0]   level_in,
  input  logic            level_valid,
  output logic            level_ready,
  input  logic            vsync,
  output logic [SEGS-1:0] bat,
  output logic [LW-1:0]   bat_level,
  output logic            busy
);

  localparam int FW = 8;

  if (2**LW <= SEGS)     begin : g_bad_lw    $error("LW too narrow for SEGS");     end
  if (STEP_FRAMES < 1)   begin : g_bad_step  $error("STEP_FRAMES must be >= 1");   end
  if (BLINK_FRAMES < 1)  begin : g_bad_blink $error("BLINK_FRAMES must be >= 1");  end
  if (LOW_THRESH > SEGS) begin : g_bad_low   $error("LOW_THRESH exceeds SEGS");    end

  logic          frame_tick;
  state_t        state;
  logic [LW-1:0] cur, target, step_tgt, next_cur, clamped;
  logic [FW-1:0] fcnt;
  logic          accept;

  vsync_tick u_vsync (
    .clk        (clk),
    .rst        (rst),
    .vsync      (vsync),
    .frame_tick (frame_tick)
  );

  assign accept  = level_valid & level_ready;
  assign clamped = (level_in > LW'(SEGS)) ? LW'(SEGS) : level_in;

  // step_tgt is latched at the tick, so a target arriving with that tick
  // only affects later steps.
  always_comb begin
    next_cur = cur;
    if (step_tgt > cur)      next_cur = cur + 1'b1;
    else if (step_tgt < cur) next_cur = cur - 1'b1;
  end

`ifdef BAT_LOW_BLINK_EN
  logic [FW-1:0] blink_fc;
  logic          blink_off;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur         <= '0;
      target      <= '0;
      step_tgt    <= '0;
      fcnt        <= '0;
      bat         <= '0;
      bat_level   <= '0;
      busy        <= 1'b0;
      level_ready <= 1'b1;
`ifdef BAT_LOW_BLINK_EN
      blink_fc    <= '0;
      blink_off   <= 1'b0;
`endif
    end else begin
      if (accept) target <= clamped;
      bat_level <= cur;
      busy      <= (cur != target);
`ifdef BAT_LOW_BLINK_EN
      if (bat_level != '0 && bat_level <= LW'(LOW_THRESH)) begin
        if (frame_tick) begin
          if (blink_fc == FW'(BLINK_FRAMES - 1)) begin
            blink_fc  <= '0;
            blink_off <= ~blink_off;
          end else begin
            blink_fc <= blink_fc + 1'b1;
          end
        end
      end else begin
        blink_fc  <= '0;
        blink_off <= 1'b0;
      end
      bat <= blink_off ? '0 : SEGS'(therm(32'(cur)));
`else
      bat <= SEGS'(therm(32'(cur)));
`endif
      case (state)
        IDLE: begin
          fcnt <= '0;
          if (cur != target) state <= WAIT;
        end
        WAIT: begin
          if (cur == target) begin
            state <= IDLE;
          end else if (frame_tick) begin
            if (fcnt == FW'(STEP_FRAMES - 1)) begin
              state       <= STEP;
              fcnt        <= '0;
              step_tgt    <= target;
              level_ready <= 1'b0;
            end else begin
              fcnt <= fcnt + 1'b1;
            end
          end
        end
        STEP: begin
          cur         <= next_cur;
          state       <= (next_cur == target) ? IDLE : WAIT;
          level_ready <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          level_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bat_level_gen.sv
// Directed bench for bat_level_gen: fill, reversal, clamp, handshake/tick
// collision, asynchronous reset and (when enabled) low-level blinking.
`timescale 1ns/1ps
module tb_bat_level_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  level_in;
  logic        level_valid;
  logic        level_ready;
  logic        vsync;
  logic [27:0] bat;
  logic [4:0]  bat_level;
  logic        busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  bat_level_gen dut (
    .clk         (clk),
    .rst         (rst),
    .level_in    (level_in),
    .level_valid (level_valid),
    .level_ready (level_ready),
    .vsync       (vsync),
    .bat         (bat),
    .bat_level   (bat_level),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic pulse();
    @(negedge clk) vsync = 1'b0;
    repeat (4) @(negedge clk);
    vsync = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic request(input logic [4:0] lv);
    @(negedge clk);
    level_in    = lv;
    level_valid = 1'b1;
    @(negedge clk);
    level_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; vsync = 1'b1; level_in = '0; level_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vec_cnt++; if (bat !== 28'h0) begin err_cnt++; $display("FAIL reset_bat: got %h want 0", bat); end
    vec_cnt++; if (bat_level !== 5'd0) begin err_cnt++; $display("FAIL reset_level: got %0d want 0", bat_level); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
    vec_cnt++; if (level_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_ready: got %b want 1", level_ready); end
  endtask

  task automatic test_fill();
    request(5'd10);
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL fill_busy_start: got %b want 1", busy); end
    for (int k = 1; k <= 20; k++) begin
      pulse();
      vec_cnt++;
      if (bat_level !== 5'(k / 2)) begin
        err_cnt++; $display("FAIL fill_level[%0d]: got %0d want %0d", k, bat_level, k / 2);
      end
      if (k == 19) begin
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL fill_busy19: got %b want 1", busy); end
      end
    end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL fill_busy20: got %b want 0", busy); end
    vec_cnt++; if (bat !== 28'h00003FF) begin err_cnt++; $display("FAIL fill_bat: got %h want 00003ff", bat); end
  endtask

  task automatic test_reverse();
    request(5'd4);
    for (int k = 1; k <= 6; k++) begin
      pulse();
      vec_cnt++;
      if (bat_level !== 5'(10 - k / 2)) begin
        err_cnt++; $display("FAIL rev_down[%0d]: got %0d want %0d", k, bat_level, 10 - k / 2);
      end
    end
    request(5'd12);
    for (int k = 1; k <= 12; k++) begin
      pulse();
      vec_cnt++;
      if (bat_level !== 5'((k >= 10) ? 12 : 7 + k / 2)) begin
        err_cnt++; $display("FAIL rev_up[%0d]: got %0d want %0d", k, bat_level, (k >= 10) ? 12 : 7 + k / 2);
      end
    end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rev_busy: got %b want 0", busy); end
    vec_cnt++; if (bat !== 28'h0000FFF) begin err_cnt++; $display("FAIL rev_bat: got %h want 0000fff", bat); end
  endtask

  task automatic test_clamp();
    request(5'd31);
    repeat (16) pulse();
    vec_cnt++; if (bat_level !== 5'd20) begin err_cnt++; $display("FAIL clamp_mid: got %0d want 20", bat_level); end
    repeat (18) pulse();
    vec_cnt++; if (bat_level !== 5'd28) begin err_cnt++; $display("FAIL clamp_level: got %0d want 28", bat_level); end
    vec_cnt++; if (bat !== 28'hFFFFFFF) begin err_cnt++; $display("FAIL clamp_bat: got %h want fffffff", bat); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL clamp_busy: got %b want 0", busy); end
  endtask

  task automatic test_simul();
    request(5'd20);
    pulse();
    @(negedge clk) vsync = 1'b0;
    repeat (3) @(negedge clk);
    vec_cnt++; if (dut.u_vsync.frame_tick !== 1'b1) begin err_cnt++; $display("FAIL simul_tick: got %b want 1", dut.u_vsync.frame_tick); end
    level_in = 5'd28; level_valid = 1'b1;
    vec_cnt++; if (dut.target !== 5'd20) begin err_cnt++; $display("FAIL simul_tgt_old: got %0d want 20", dut.target); end
    @(negedge clk) level_valid = 1'b0;
    vec_cnt++; if (dut.target !== 5'd28) begin err_cnt++; $display("FAIL simul_tgt_new: got %0d want 28", dut.target); end
    vsync = 1'b1;
    repeat (6) @(negedge clk);
    vec_cnt++; if (bat_level !== 5'd27) begin err_cnt++; $display("FAIL simul_step: got %0d want 27", bat_level); end
    repeat (2) pulse();
    vec_cnt++; if (bat_level !== 5'd28) begin err_cnt++; $display("FAIL simul_back: got %0d want 28", bat_level); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL simul_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int ticks;
    do_reset();
    request(5'd6);
    repeat (12) pulse();
    vec_cnt++; if (bat_level !== 5'd6) begin err_cnt++; $display("FAIL rmid_pre: got %0d want 6", bat_level); end
    request(5'd10);
    pulse();
    @(posedge clk); #2 rst = 1'b1;
    #1;
    vec_cnt++; if (bat !== 28'h0) begin err_cnt++; $display("FAIL rmid_bat: got %h want 0", bat); end
    vec_cnt++; if (bat_level !== 5'd0) begin err_cnt++; $display("FAIL rmid_level: got %0d want 0", bat_level); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rmid_busy: got %b want 0", busy); end
    vec_cnt++; if (level_ready !== 1'b1) begin err_cnt++; $display("FAIL rmid_ready: got %b want 1", level_ready); end
    @(negedge clk) rst = 1'b0;
    ticks = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (dut.u_vsync.frame_tick) ticks++;
    end
    vec_cnt++; if (ticks !== 0) begin err_cnt++; $display("FAIL rmid_ticks: got %0d want 0", ticks); end
    vec_cnt++; if (bat_level !== 5'd0) begin err_cnt++; $display("FAIL rmid_post: got %0d want 0", bat_level); end
  endtask

`ifdef BAT_LOW_BLINK_EN
  task automatic test_blink();
    logic [27:0] exp_bat;
    do_reset();
    request(5'd3);
    repeat (6) pulse();
    for (int k = 7; k <= 50; k++) begin
      pulse();
      exp_bat = ((((k - 2) / 16) % 2) == 1) ? 28'h0 : 28'h0000007;
      vec_cnt++;
      if (bat !== exp_bat) begin
        err_cnt++; $display("FAIL blink_bat[%0d]: got %h want %h", k, bat, exp_bat);
      end
      vec_cnt++;
      if (bat_level !== 5'd3) begin
        err_cnt++; $display("FAIL blink_level[%0d]: got %0d want 3", k, bat_level);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_reverse();
    test_clamp();
    test_simul();
    test_reset_mid();
`ifdef BAT_LOW_BLINK_EN
    test_blink();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
